// File: rtl/dcache_assoc_wb.sv
// N-way set-associative, write-back, write-allocate data cache sitting between
// the MEM stage and a block-wide data memory. True-LRU replacement, byte-masked
// stores, zero-stall read and write hits.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   read, write              load / store request, held until busywait is low
//   write_mask[3:0]          byte enables for a store
//   address[31:0]            byte address, bits [1:0] ignored
//   writedata[31:0]          store data
//   Inst_hit                 request is only honoured while this is high
//   readdata[31:0]           load data, valid on a read hit
//   busywait                 pipeline stall
//   mem_Read, mem_Write      block fetch / write-back requests
//   mem_Address              block address {tag, index}
//   mem_Writedata[BLKW]      victim block being written back
//   mem_Readdata[BLKW]       fetched block
//   mem_BusyWait             transfer completes on an edge where this is low
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits; on a miss latch the request and pick a victim
// WRITEBACK | write the dirty victim block to memory
// FETCH     | read the requested block into the victim way

module dcache_assoc_wb #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 4,
    localparam int OFFB = $clog2(WORDS),
    localparam int IDXB = $clog2(SETS),
    localparam int TAGB = 30 - IDXB - OFFB,
    localparam int BLKW = 32 * WORDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [3:0]        write_mask,
    input  logic [31:0]       address,
    input  logic [31:0]       writedata,
    input  logic              Inst_hit,
    output logic [31:0]       readdata,
    output logic              busywait,
    output logic              mem_Read,
    output logic              mem_Write,
    output logic [29-OFFB:0]  mem_Address,
    output logic [BLKW-1:0]   mem_Writedata,
    input  logic [BLKW-1:0]   mem_Readdata,
    input  logic              mem_BusyWait
);

    localparam int WAYB = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t state;

    logic [WAYS-1:0]        valid_q [SETS];
    logic [WAYS-1:0]        dirty_q [SETS];
    logic [TAGB-1:0]        tag_q   [SETS][WAYS];
    logic [WORDS-1:0][31:0] data_q  [SETS][WAYS];
    logic [WAYB-1:0]        age_q   [SETS][WAYS];

    logic [OFFB-1:0] offset;
    logic [IDXB-1:0] index;
    logic [TAGB-1:0] tag;
    logic            req;
    logic            unused_addr_bits;

    assign offset           = address[OFFB+1:2];
    assign index            = address[OFFB+IDXB+1:OFFB+2];
    assign tag              = address[31:OFFB+IDXB+2];
    assign req              = (read | write) & Inst_hit;
    assign unused_addr_bits = ^address[1:0];

    // Request fields captured when a miss leaves IDLE; the fill targets these
    // even if the pipeline changes address or drops the request mid-miss.
    logic [IDXB-1:0] miss_index;
    logic [TAGB-1:0] miss_tag;
    logic [WAYB-1:0] miss_way;

    logic            hit;
    logic [WAYB-1:0] hit_way;
    logic [WAYB-1:0] victim;
    logic            have_free;
    logic [31:0]     merged;
    logic            fill_done;
    logic            touch_en;
    logic [IDXB-1:0] touch_set;
    logic [WAYB-1:0] touch_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index][w] && tag_q[index][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAYB'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the oldest way. Ages are a
    // permutation, so the oldest way is the one whose age is WAYS-1.
    always_comb begin
        victim    = '0;
        have_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[index][w]) begin
                victim    = WAYB'(w);
                have_free = 1'b1;
            end
        end
        if (!have_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[index][w] == WAYB'(WAYS - 1)) begin
                    victim = WAYB'(w);
                end
            end
        end
    end

    always_comb begin
        merged = data_q[index][hit_way][offset];
        for (int i = 0; i < 4; i++) begin
            if (write_mask[i]) begin
                merged[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    // Gated by hit so the output never exposes the uninitialised data array.
    assign readdata = hit ? data_q[index][hit_way][offset] : '0;
    assign busywait = req & ~((state == IDLE) & hit);

    assign fill_done = (state == FETCH) && !mem_BusyWait;
    assign touch_en  = fill_done || ((state == IDLE) && req && hit);
    assign touch_set = fill_done ? miss_index : index;
    assign touch_way = fill_done ? miss_way : hit_way;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mem_Read      <= 1'b0;
            mem_Write     <= 1'b0;
            mem_Address   <= '0;
            mem_Writedata <= '0;
            miss_index    <= '0;
            miss_tag      <= '0;
            miss_way      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAYB'(w);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (write) begin
                            data_q[index][hit_way][offset] <= merged;
                            dirty_q[index][hit_way]        <= 1'b1;
                        end
                    end else if (req) begin
                        miss_index <= index;
                        miss_tag   <= tag;
                        miss_way   <= victim;
                        if (valid_q[index][victim] && dirty_q[index][victim]) begin
                            state         <= WRITEBACK;
                            mem_Write     <= 1'b1;
                            mem_Address   <= {tag_q[index][victim], index};
                            mem_Writedata <= data_q[index][victim];
                        end else begin
                            state       <= FETCH;
                            mem_Read    <= 1'b1;
                            mem_Address <= {tag, index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_BusyWait) begin
                        state       <= FETCH;
                        mem_Write   <= 1'b0;
                        mem_Read    <= 1'b1;
                        mem_Address <= {miss_tag, miss_index};
                    end
                end
                FETCH: begin
                    if (!mem_BusyWait) begin
                        state                          <= IDLE;
                        mem_Read                       <= 1'b0;
                        data_q[miss_index][miss_way]   <= mem_Readdata;
                        tag_q[miss_index][miss_way]    <= miss_tag;
                        valid_q[miss_index][miss_way]  <= 1'b1;
                        dirty_q[miss_index][miss_way]  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // True LRU: ways younger than the touched way age by one, the
            // touched way becomes MRU.
            if (WAYS > 1 && touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAYB'(w) == touch_way) begin
                        age_q[touch_set][w] <= '0;
                    end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                        age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_assoc_wb.sv
`timescale 1ns/1ps
module tb_dcache_assoc_wb;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 4;
    localparam int BLKW  = 32 * WORDS;

    logic              clock;
    logic              reset;
    logic              read;
    logic              write;
    logic [3:0]        write_mask;
    logic [31:0]       address;
    logic [31:0]       writedata;
    logic              Inst_hit;
    logic [31:0]       readdata;
    logic              busywait;
    logic              mem_Read;
    logic              mem_Write;
    logic [27:0]       mem_Address;
    logic [BLKW-1:0]   mem_Writedata;
    logic [BLKW-1:0]   mem_Readdata;
    logic              mem_BusyWait;

    dcache_assoc_wb #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .write_mask(write_mask), .address(address), .writedata(writedata),
        .Inst_hit(Inst_hit), .readdata(readdata), .busywait(busywait),
        .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Address(mem_Address),
        .mem_Writedata(mem_Writedata), .mem_Readdata(mem_Readdata),
        .mem_BusyWait(mem_BusyWait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- block memory model ----------------
    int              lat = 3;
    int              mem_cnt;
    logic [BLKW-1:0] mem [64];
    bit              mem_wr [64];
    int              wr_done;
    int              rd_hi;
    int              overlap;

    typedef struct {
        bit              w;
        int              addr;
        logic [BLKW-1:0] data;
    } xfer_t;
    xfer_t xlog[$];

    function automatic logic [31:0] pat(int wa);
        logic [31:0] x;
        x = wa;
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [BLKW-1:0] blk(int ba);
        logic [BLKW-1:0] b;
        if (mem_wr[ba]) return mem[ba];
        for (int w = 0; w < WORDS; w++) b[32*w +: 32] = pat(ba * WORDS + w);
        return b;
    endfunction

    assign mem_BusyWait = (mem_Read | mem_Write) && (mem_cnt < lat);

    always @(negedge clock) mem_Readdata = blk(int'(mem_Address[5:0]));

    always @(posedge clock) begin
        if (mem_Read && mem_Write) overlap <= overlap + 1;
        if (mem_Read) rd_hi <= rd_hi + 1;
        if (reset) begin
            mem_cnt <= 0;
        end else if (mem_Read || mem_Write) begin
            if (!mem_BusyWait) begin
                mem_cnt <= 0;
                if (mem_Write) begin
                    mem[mem_Address[5:0]]    <= mem_Writedata;
                    mem_wr[mem_Address[5:0]] <= 1'b1;
                    wr_done <= wr_done + 1;
                end
                xlog.push_back('{mem_Write, int'(mem_Address), mem_Writedata});
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input bit inst,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int stall, output logic [31:0] rdata,
                          output int rdcyc, output int wbs);
        int r0, w0;
        r0 = rd_hi;
        w0 = wr_done;
        @(negedge clock);
        read = rd; write = wr; Inst_hit = inst;
        address = a; writedata = d; write_mask = m;
        #1;
        stall = 0;
        while (busywait && stall < 200) begin
            stall++;
            @(negedge clock);
            #1;
        end
        if (stall >= 200) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr %h still busy after %0d cycles, required release", a, stall);
        end
        rdata = readdata;
        @(posedge clock);
        #1;
        read = 1'b0; write = 1'b0;
        rdcyc = rd_hi - r0;
        wbs   = wr_done - w0;
    endtask

    // ---------------- behavioural reference ----------------
    int        lru_q [SETS][$];    // per set: tags in most-recent-first order
    bit        dirty_m [int];      // keyed by block address
    logic [31:0] ref_w [int];      // latest stored value per word address

    function automatic logic [31:0] ref_word(int wa);
        logic [BLKW-1:0] b;
        if (ref_w.exists(wa)) return ref_w[wa];
        b = blk(wa / WORDS);
        return b[32*(wa % WORDS) +: 32];
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; read = 1'b0; write = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < SETS; s++) lru_q[s].delete();
        dirty_m.delete();
        ref_w.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rd, wr, inst, chkd;
        logic [31:0] a, d, ed;
        logic [3:0]  m;
        int          es, erc, ewb;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t R(logic [31:0] a, logic [31:0] ed, int es, int erc, int ewb);
        vec_t v;
        v = '{rd:1, wr:0, inst:1, chkd:1, a:a, d:0, ed:ed, m:0, es:es, erc:erc, ewb:ewb};
        return v;
    endfunction

    function automatic vec_t W(logic [31:0] a, logic [31:0] d, logic [3:0] m, int es, int erc, int ewb);
        vec_t v;
        v = '{rd:0, wr:1, inst:1, chkd:0, a:a, d:d, ed:0, m:m, es:es, erc:erc, ewb:ewb};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          stall, rdcyc, wbs;
        logic [31:0] rdata;
        vec_t        v;

        reset = 1'b1; read = 1'b0; write = 1'b0; Inst_hit = 1'b1;
        write_mask = 4'h0; address = '0; writedata = '0;
        mem_cnt = 0; wr_done = 0; rd_hi = 0; overlap = 0;
        do_reset();

        #1;
        chk("reset busywait", busywait, 0);
        chk("reset mem_Read", mem_Read, 0);
        chk("reset mem_Write", mem_Write, 0);
        chk("reset readdata known", ((^readdata) === 1'bx), 0);

        // set 4 (index 4): tags 0 (0x40), 1 (0xC0), 2 (0x140), 3 (0x1C0)
        tbl.push_back(R(32'h40,  pat(32'h10), 5, 4, 0));
        tbl.push_back(R(32'h40,  pat(32'h10), 0, 0, 0));
        tbl.push_back(W(32'h44,  32'h1122_3344, 4'hF, 0, 0, 0));
        tbl.push_back(W(32'h44,  32'hAABB_CCDD, 4'b0110, 0, 0, 0));
        tbl.push_back(R(32'h44,  32'h11BB_CC44, 0, 0, 0));
        tbl.push_back(W(32'h48,  32'hFFFF_FFFF, 4'h0, 0, 0, 0));
        tbl.push_back(R(32'h48,  pat(32'h12), 0, 0, 0));
        tbl.push_back(R(32'hC0,  pat(32'h30), 5, 4, 0));
        tbl.push_back(R(32'h40,  pat(32'h10), 0, 0, 0));
        tbl.push_back(R(32'h140, pat(32'h50), 5, 4, 0));
        tbl.push_back(R(32'h40,  pat(32'h10), 0, 0, 0));
        tbl.push_back(R(32'hC4,  pat(32'h31), 5, 4, 0));
        tbl.push_back(W(32'h1C0, 32'hCAFE_F00D, 4'hF, 9, 4, 1));
        tbl.push_back(R(32'h44,  32'h11BB_CC44, 5, 4, 0));
        v = R(32'h1C0, 0, 0, 0, 0);
        v.inst = 0; v.chkd = 0;
        tbl.push_back(v);
        tbl.push_back(R(32'hC0,  pat(32'h30), 9, 4, 1));
        tbl.push_back(R(32'h1C0, 32'hCAFE_F00D, 5, 4, 0));

        lat = 3;
        xlog.delete();
        foreach (tbl[i]) begin
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].inst, tbl[i].a, tbl[i].d, tbl[i].m,
                   stall, rdata, rdcyc, wbs);
            chk($sformatf("t%0d stall", i), stall, tbl[i].es);
            chk($sformatf("t%0d mem_Read cycles", i), rdcyc, tbl[i].erc);
            chk($sformatf("t%0d writebacks", i), wbs, tbl[i].ewb);
            if (tbl[i].chkd) chk($sformatf("t%0d readdata", i), rdata, tbl[i].ed);
            if (i == 0) begin
                chk("t0 first xfer is read", (xlog.size() > 0) ? {31'b0, xlog[0].w} : 32'hFFFF_FFFF, 0);
                if (xlog.size() > 0) chk("t0 fetch address", xlog[0].addr, 32'h4);
            end
        end

        // dirty miss with a slow memory, set 1: A=0x10, B=0x90, C=0x110
        lat = 10;
        do_req(1, 0, 1, 32'h10, 0, 0, stall, rdata, rdcyc, wbs);
        chk("slow A stall", stall, 12);
        do_req(0, 1, 1, 32'h90, 32'h1234_5678, 4'hF, stall, rdata, rdcyc, wbs);
        chk("slow B stall", stall, 12);
        do_req(1, 0, 1, 32'h10, 0, 0, stall, rdata, rdcyc, wbs);
        chk("slow A hit stall", stall, 0);
        xlog.delete();
        do_req(1, 0, 1, 32'h110, 0, 0, stall, rdata, rdcyc, wbs);
        chk("slow C stall", stall, 23);
        chk("slow C writebacks", wbs, 1);
        chk("slow C xfer count", xlog.size(), 2);
        if (xlog.size() >= 2) begin
            chk("slow wb first", xlog[0].w, 1);
            chk("slow wb address", xlog[0].addr, 32'h9);
            chk("slow wb data", xlog[0].data[31:0], 32'h1234_5678);
            chk("slow fetch second", xlog[1].w, 0);
            chk("slow fetch address", xlog[1].addr, 32'h11);
        end
        do_req(1, 0, 1, 32'h110, 0, 0, stall, rdata, rdcyc, wbs);
        chk("slow C rehit", stall, 0);
        do_req(1, 0, 1, 32'h10, 0, 0, stall, rdata, rdcyc, wbs);
        chk("slow A still hits", stall, 0);

        // reset in the second FETCH cycle
        lat = 3;
        @(negedge clock);
        read = 1'b1; Inst_hit = 1'b1; address = 32'h20;
        #1;
        chk("rst-fetch miss busy", busywait, 1);
        @(negedge clock);
        chk("rst-fetch fetching", mem_Read, 1);
        @(negedge clock);
        reset = 1'b1; read = 1'b0;
        @(posedge clock);
        #1;
        chk("rst-fetch mem_Read", mem_Read, 0);
        chk("rst-fetch mem_Write", mem_Write, 0);
        chk("rst-fetch busywait", busywait, 0);
        @(negedge clock);
        reset = 1'b0;
        do_req(1, 0, 1, 32'h20, 0, 0, stall, rdata, rdcyc, wbs);
        chk("rst-fetch re-miss", stall, 5);
        chk("rst-fetch data", rdata, pat(32'h8));
        do_req(1, 0, 1, 32'h110, 0, 0, stall, rdata, rdcyc, wbs);
        chk("post-reset miss", stall, 5);

        // randomized traffic against the recency-list model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int tg, ix, off, ba, wa, pos, es, erc, ewb, vt, vb;
            bit rd, inst;
            logic [31:0] a, d, ed, nw;
            logic [3:0] m;
            tg   = $urandom_range(0, 5);
            ix   = $urandom_range(0, 1);
            off  = $urandom_range(0, 3);
            ba   = tg * SETS + ix;
            wa   = ba * WORDS + off;
            a    = (wa * 4) + $urandom_range(0, 3);
            rd   = $urandom_range(0, 1);
            inst = ($urandom_range(0, 9) != 0);
            d    = $urandom;
            m    = 4'($urandom_range(0, 15));
            lat  = $urandom_range(0, 3);
            ed   = ref_word(wa);
            es = 0; erc = 0; ewb = 0;
            if (inst) begin
                pos = -1;
                foreach (lru_q[ix][k]) if (lru_q[ix][k] == tg) pos = k;
                if (pos >= 0) begin
                    lru_q[ix].delete(pos);
                end else begin
                    if (lru_q[ix].size() == WAYS) begin
                        vt = lru_q[ix].pop_back();
                        vb = vt * SETS + ix;
                        if (dirty_m.exists(vb)) begin
                            ewb = 1;
                            dirty_m.delete(vb);
                        end
                    end
                    erc = lat + 1;
                    es  = 1 + erc + (ewb ? lat + 1 : 0);
                end
                lru_q[ix].push_front(tg);
                if (!rd) begin
                    dirty_m[ba] = 1'b1;
                    nw = ed;
                    for (int b = 0; b < 4; b++) if (m[b]) nw[8*b +: 8] = d[8*b +: 8];
                    ref_w[wa] = nw;
                end
            end
            do_req(rd, !rd, inst, a, d, m, stall, rdata, rdcyc, wbs);
            chk($sformatf("r%0d stall", n), stall, es);
            chk($sformatf("r%0d mem_Read cycles", n), rdcyc, erc);
            chk($sformatf("r%0d writebacks", n), wbs, ewb);
            if (rd && inst) chk($sformatf("r%0d readdata", n), rdata, ed);
        end

        chk("read/write overlap cycles", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_assoc_wb.md
Name: dcache_assoc_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the MEM stage and the block-wide data memory.
- Successor of the 8-line direct-mapped data cache. Generalised in sets, ways and block size.
- Adds true-LRU replacement, byte-masked stores (sb/sh/sw) and fully synchronous operation with no delay annotations.
- Carries forward the `Inst_hit` qualification so that requests from stale instruction fetches are ignored.

Parameters:
- SETS, 8: number of sets; power of 2, at least 2.
- WAYS, 2: associativity; one of 1, 2 or 4.
- WORDS, 4: 32-bit words per block; power of 2, at least 2.
- Derived OFFB = log2(WORDS); IDXB = log2(SETS); TAGB = 30 - IDXB - OFFB; BLKW = 32*WORDS.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- read  in  1  load request, held until busywait is low
- write  in  1  store request, held until busywait is low; read and write both high is illegal
- write_mask  in  4  byte enables for a store; bit i covers writedata[8i+7:8i]
- address  in  32  byte address; bits [1:0] are ignored
- writedata  in  32  store data
- Inst_hit  in  1  request is valid only while this is high
- readdata  out  32  load data; valid while read=1 and busywait=0
- busywait  out  1  stall the pipeline
- mem_Read  out  1  block fetch request
- mem_Write  out  1  block write-back request
- mem_Address  out  32-2-OFFB  block address
- mem_Writedata  out  BLKW  victim block
- mem_Readdata  in  BLKW  fetched block
- mem_BusyWait  in  1  memory busy; a transfer completes on a rising edge where the request is high and mem_BusyWait is 0

Behaviour:
- Address split: offset = address[OFFB+1:2]; index = address[OFFB+IDXB+1:OFFB+2]; tag = address[31:OFFB+IDXB+2].
- Per line state: valid, dirty, tag, data. Per set: one LRU age of log2(WAYS) bits per way, where 0 is MRU. For WAYS=1 the LRU logic is absent.
- Request: req = (read | write) & Inst_hit.
- Hit: some way w in the set is valid with a matching tag. Hit detection is combinational.
- busywait = req & !(state==IDLE & hit).
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, read hit: readdata = the selected word of way w, combinational, so there is zero stall cycles. LRU updates at the next edge.
- IDLE, write hit: at the next edge, the bytes enabled by write_mask are merged into the word, dirty is set and LRU updates. busywait is already low in the request cycle.
- IDLE, miss: choose the victim as the lowest-numbered invalid way; otherwise the way with the maximum age. Go to WRITEBACK if the victim is valid and dirty, else go to FETCH.
- WRITEBACK:
  - mem_Write=1.
  - mem_Address = {victim tag, index}.
  - mem_Writedata = victim data.
  - On completion, go to FETCH.
- FETCH:
  - mem_Read=1.
  - mem_Address = {tag, index}.
  - On completion, write mem_Readdata into the victim way, set valid=1, dirty=0, tag=tag, and go to IDLE.
  - The request then hits in IDLE, so a miss costs 1 + transfer cycles.
- Victim way and request fields are registered on leaving IDLE. Address or Inst_hit changing mid-miss does not corrupt the fill; the fill completes for the latched address.
- A request dropped during a miss: the fill still completes and no write merges.
- LRU update on an access to way w:
  - Ways whose age is less than age(w) increment.
  - age(w) becomes 0.
  - Fills count as accesses.
  - Ages stay a permutation of 0..WAYS-1.
- mem_Read and mem_Write are never both high. Both are 0 in IDLE.
- write_mask = 0 on a write hit: busywait still drops, the line is marked dirty and data is unchanged.
- Reset:
  - Clears all valid and dirty bits.
  - Sets ages to way index.
  - State goes to IDLE, so mem_Read, mem_Write and busywait read 0 after the edge.
  - Reset during WRITEBACK or FETCH abandons the transfer. Dirty data is lost by design.
  - Data and tag arrays are not cleared.
- readdata while not a read hit: don't-care, but must be X-free after reset.

Test Plan:
- Reset, then read 0x0000_0040 with memory returning block W0..W3 after 3 busy cycles → mem_Read high for 4 cycles, mem_Address=0x0000_004; re-read returns W0 with busywait low the same cycle.
- Write 0xAABBCCDD mask 4'b0110 to a hit word holding 0x11223344 → a later read gives 0x11BBCC44 and the line is dirty.
- WAYS=2, SETS=8, WORDS=4: fill set 0 with tags A and B, read A, then miss on tag C → B is evicted and A still hits. If B was dirty, mem_Write carries B's block with mem_Address={B,0} before mem_Read.
- Dirty miss with mem_BusyWait held high for 10 cycles → busywait stays high throughout, then the WRITEBACK→FETCH order, then a hit. mem_Read and mem_Write never overlap.
- Assert reset in the second cycle of FETCH → the next cycle has mem_Read=0 and busywait=0; a following read of the same address misses.
- read=1 with Inst_hit=0 → busywait=0, no memory traffic, LRU unchanged.
